// File: rtl/lc3b_muldiv_pkg.sv
// lc3b_muldiv_pkg: shared LC-3b types for the multiply/divide unit.
// Holds the MDU opcode enum, ALU op enum and decode helpers.
package lc3b_muldiv_pkg;

  typedef enum logic [1:0] {
    MDU_MULU = 2'b00,
    MDU_DIVU = 2'b01,
    MDU_MULS = 2'b10,
    MDU_DIVS = 2'b11
  } lc3b_mdu_op;

  typedef enum logic [3:0] {
    alu_add,
    alu_and,
    alu_not,
    alu_pass,
    alu_sll,
    alu_srl,
    alu_sra,
    alu_mul,
    alu_div
  } lc3b_aluop;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_RUN,
    MDU_DONE
  } lc3b_mdu_state;

  function automatic logic mdu_is_div(lc3b_mdu_op op);
    return (op == MDU_DIVU) || (op == MDU_DIVS);
  endfunction

  function automatic logic mdu_is_signed(lc3b_mdu_op op);
    return (op == MDU_MULS) || (op == MDU_DIVS);
  endfunction

endpackage

// File: rtl/lc3b_cond_negate.sv
// lc3b_cond_negate: two's-complement negate when enabled.
// Used for signed operand magnitudes and result sign fixup.
module lc3b_cond_negate #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = en_i ? ('0 - a_i) : a_i;

endmodule

// File: rtl/lc3b_muldiv.sv
// lc3b_muldiv: iterative shift-add multiply / restoring divide.
// Define LC3B_MULDIV_SIGNED_EN to give MULS/DIVS signed semantics.
module lc3b_muldiv
  import lc3b_muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_lo,
  output logic [WIDTH-1:0] resp_hi,
  output logic             resp_dz
);

  localparam int CW = $clog2(WIDTH);

  lc3b_mdu_state      state_q;
  lc3b_mdu_op         op_in;
  logic [CW-1:0]      count_q;
  logic               init_q;
  logic               div_q;
  logic               dz_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   d_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic               resp_dz_q;
  logic [WIDTH-1:0]   resp_lo_q;
  logic [WIDTH-1:0]   resp_hi_q;

  assign op_in = lc3b_mdu_op'(req_op);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  assign hi = acc_q[2*WIDTH-1:WIDTH];
  assign lo = acc_q[WIDTH-1:0];

  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_step;
  assign msum     = {1'b0, hi} + (lo[0] ? {1'b0, d_q} : '0);
  assign mul_step = {msum, lo[WIDTH-1:1]};

  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   nrem;
  logic [2*WIDTH-1:0] div_step;
  assign shl      = {hi, lo[WIDTH-1]};
  assign diff     = shl - {1'b0, d_q};
  assign nrem     = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
  assign div_step = {nrem, lo[WIDTH-2:0], ~diff[WIDTH]};

  logic [2*WIDTH-1:0] step;
  assign step = div_q ? div_step : mul_step;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;

`ifdef LC3B_MULDIV_SIGNED_EN
  logic               sgn_q;
  logic               sa;
  logic               sb;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign sa = sgn_q & a_q[WIDTH-1];
  assign sb = sgn_q & b_q[WIDTH-1];

  lc3b_cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .a_i(a_q), .en_i(sa), .y_o(a_mag)
  );
  lc3b_cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .a_i(b_q), .en_i(sb), .y_o(b_mag)
  );
  lc3b_cond_negate #(.WIDTH(2*WIDTH)) u_neg_p (
    .a_i(step), .en_i(sa ^ sb), .y_o(prod_fix)
  );
  // A zero divisor keeps the all-ones quotient unsigned.
  lc3b_cond_negate #(.WIDTH(WIDTH)) u_neg_q (
    .a_i(step[WIDTH-1:0]), .en_i((sa ^ sb) & ~dz_q), .y_o(quo_fix)
  );
  lc3b_cond_negate #(.WIDTH(WIDTH)) u_neg_r (
    .a_i(step[2*WIDTH-1:WIDTH]), .en_i(sa), .y_o(rem_fix)
  );

  assign res_lo = div_q ? quo_fix : prod_fix[WIDTH-1:0];
  assign res_hi = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
`else
  assign a_mag  = a_q;
  assign b_mag  = b_q;
  assign res_lo = step[WIDTH-1:0];
  assign res_hi = step[2*WIDTH-1:WIDTH];
`endif

  // Control FSM: accept, one init cycle, WIDTH iterations, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MDU_IDLE;
      count_q      <= '0;
      init_q       <= 1'b0;
      div_q        <= 1'b0;
      dz_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      d_q          <= '0;
      acc_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_dz_q    <= 1'b0;
      resp_lo_q    <= '0;
      resp_hi_q    <= '0;
`ifdef LC3B_MULDIV_SIGNED_EN
      sgn_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (req_valid) begin
            div_q       <= mdu_is_div(op_in);
            dz_q        <= mdu_is_div(op_in) && (req_b == '0);
            a_q         <= req_a;
            b_q         <= req_b;
            count_q     <= CW'(WIDTH - 1);
            init_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= MDU_RUN;
`ifdef LC3B_MULDIV_SIGNED_EN
            sgn_q       <= mdu_is_signed(op_in);
`endif
          end
        end
        MDU_RUN: begin
          if (init_q) begin
            // Operand magnitudes enter the core here, off the req path.
            init_q <= 1'b0;
            d_q    <= div_q ? b_mag : a_mag;
            acc_q  <= {{WIDTH{1'b0}}, div_q ? a_mag : b_mag};
          end else begin
            acc_q <= step;
            if (count_q == '0) begin
              resp_lo_q    <= res_lo;
              resp_hi_q    <= res_hi;
              resp_dz_q    <= dz_q;
              resp_valid_q <= 1'b1;
              state_q      <= MDU_DONE;
            end else begin
              count_q <= count_q - 1'b1;
            end
          end
        end
        MDU_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= MDU_IDLE;
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_lo    = resp_lo_q;
  assign resp_hi    = resp_hi_q;
  assign resp_dz    = resp_dz_q;

endmodule
